// File: rtl/switch_pkg.sv
// Shared types and helpers for the 4-port packet switch.
package switch_pkg;

  localparam int unsigned N_PORTS = 4;
  localparam int unsigned BYTE_W  = 8;

  typedef struct packed {
    logic [BYTE_W-1:0] addr;
    logic [BYTE_W-1:0] data;
  } pkt_t;

  // Extract lane idx from a bus of N_PORTS packed bytes.
  function automatic logic [BYTE_W-1:0] lane_slice(input logic [N_PORTS*BYTE_W-1:0] bus,
                                                   input int unsigned idx);
    return bus[idx*BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter; rr_i names the highest-priority lane.
module rr_arbiter4
  import switch_pkg::*;
(
  input  logic [N_PORTS-1:0] req_i,
  input  logic [1:0]         rr_i,
  input  logic               en_i,
  output logic [N_PORTS-1:0] grant_o,
  output logic [1:0]         rr_next_o
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    grant_o   = '0;
    rr_next_o = rr_i;
    found     = 1'b0;
    idx       = rr_i;
    for (int unsigned off = 0; off < N_PORTS; off++) begin
      idx = rr_i + 2'(off);
      if (en_i && req_i[idx] && !found) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        rr_next_o    = idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/switch_out_port.sv
// Output-port stage: address match, round-robin arbitration, FIFO and receiver handshake.
module switch_out_port
  import switch_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PORT_ADDR = 8'h00,
  parameter int unsigned       DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_PORTS*BYTE_W-1:0] addr_in,
  input  logic [N_PORTS*BYTE_W-1:0] data_in,
  input  logic [N_PORTS-1:0]        valid_in,
  output logic [N_PORTS-1:0]        grant,
  output logic [BYTE_W-1:0]         addr_out,
  output logic [BYTE_W-1:0]         data_out,
  output logic                      valid_out,
  output logic                      rcv_rdy,
  input  logic                      data_rd
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StDeliver = 1'b1;

  pkt_t            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [1:0]      rr_q, rr_d;
  logic [0:0]      state_q;
  pkt_t            out_q;

  logic [N_PORTS-1:0] req;
  logic               push, pop, space;
  pkt_t               wr_pkt;

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      req[i] = valid_in[i] && (lane_slice(addr_in, i) == PORT_ADDR);
    end
  end

  assign rcv_rdy = (count_q != '0);
  assign pop     = data_rd && rcv_rdy;
  // A pop frees the slot at the same edge, so a full FIFO can still accept.
  assign space   = (count_q < CntW'(DEPTH)) || pop;

  rr_arbiter4 u_arb (
    .req_i     (req),
    .rr_i      (rr_q),
    .en_i      (space && reset),
    .grant_o   (grant),
    .rr_next_o (rr_d)
  );

  assign push = |grant;

  always_comb begin
    wr_pkt = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (grant[i]) begin
        wr_pkt.addr = lane_slice(addr_in, i);
        wr_pkt.data = lane_slice(data_in, i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= '0;
      state_q  <= StIdle;
      out_q    <= '0;
    end else begin
      rr_q <= rr_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        out_q    <= mem_q[rd_ptr_q];
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      state_q <= pop ? StDeliver : StIdle;
    end
  end

  assign valid_out = (state_q == StDeliver);
  assign addr_out  = out_q.addr;
  assign data_out  = out_q.data;

endmodule

// File: tb/tb_switch_out_port.sv
// Directed bench for switch_out_port with hand-computed expectations.
module tb_switch_out_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr_in, data_in;
  logic [3:0]  valid_in, grant;
  logic [7:0]  addr_out, data_out;
  logic        valid_out, rcv_rdy, data_rd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  switch_out_port #(.PORT_ADDR(8'h00), .DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .grant     (grant),
    .addr_out  (addr_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .rcv_rdy   (rcv_rdy),
    .data_rd   (data_rd)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] d);
    addr_in[8*i +: 8] = a;
    data_in[8*i +: 8] = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    addr_in  = '0;
    data_in  = '0;
    valid_in = '0;
    data_rd  = 1'b0;
    #2;
    // Grant must stay low while reset is held, even with a matching request.
    valid_in = 4'b0001;
    #1;
    check_eq("grant_in_reset", 32'(grant), 32'h0);
    tick();
    valid_in = '0;
    tick();
    reset = 1'b1;
    check_eq("rst_valid_out", 32'(valid_out), 32'h0);
    check_eq("rst_rcv_rdy", 32'(rcv_rdy), 32'h0);
    check_eq("rst_addr_out", 32'(addr_out), 32'h0);
    check_eq("rst_data_out", 32'(data_out), 32'h0);

    // 1. pass-through on lane 2
    set_lane(2, 8'h00, 8'hA5);
    valid_in = 4'b0100;
    #1;
    check_eq("t1_grant", 32'(grant), 32'h4);
    tick();
    valid_in = '0;
    check_eq("t1_rcv_rdy", 32'(rcv_rdy), 32'h1);
    check_eq("t1_no_valid", 32'(valid_out), 32'h0);
    data_rd = 1'b1;
    tick();
    data_rd = 1'b0;
    check_eq("t1_valid_out", 32'(valid_out), 32'h1);
    check_eq("t1_addr_out", 32'(addr_out), 32'h00);
    check_eq("t1_data_out", 32'(data_out), 32'hA5);
    check_eq("t1_rcv_rdy_low", 32'(rcv_rdy), 32'h0);
    tick();
    check_eq("t1_valid_drop", 32'(valid_out), 32'h0);

    // 2. contention from lane 0 after a fresh reset
    do_reset();
    for (int i = 0; i < 4; i++) set_lane(i, 8'h00, 8'(8'h10 + i));
    valid_in = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq($sformatf("t2_grant%0d", k), 32'(grant), 32'(1 << k));
      tick();
      valid_in[k] = 1'b0;
    end
    data_rd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("t2_valid%0d", k), 32'(valid_out), 32'h1);
      check_eq($sformatf("t2_data%0d", k), 32'(data_out), 32'(8'h10 + k));
    end
    data_rd = 1'b0;
    tick();
    check_eq("t2_idle", 32'(valid_out), 32'h0);
    check_eq("t2_empty", 32'(rcv_rdy), 32'h0);

    // 3. address filter
    set_lane(1, 8'h03, 8'h77);
    valid_in = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq($sformatf("t3_grant%0d", k), 32'(grant), 32'h0);
      tick();
      check_eq($sformatf("t3_empty%0d", k), 32'(rcv_rdy), 32'h0);
    end
    valid_in = '0;

    // 4. fill to full, then push with a simultaneous pop
    for (int k = 0; k < 8; k++) begin
      set_lane(0, 8'h00, 8'(k));
      valid_in = 4'b0001;
      #1;
      check_eq($sformatf("t4_grant%0d", k), 32'(grant), 32'h1);
      tick();
    end
    set_lane(0, 8'h00, 8'h08);
    #1;
    check_eq("t4_full_nogrant", 32'(grant), 32'h0);
    check_eq("t4_full_rdy", 32'(rcv_rdy), 32'h1);
    tick();
    check_eq("t4_full_nogrant2", 32'(grant), 32'h0);
    data_rd = 1'b1;
    #1;
    check_eq("t4_pop_grant", 32'(grant), 32'h1);
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k == 0) valid_in = '0;
      check_eq($sformatf("t4_valid%0d", k), 32'(valid_out), 32'h1);
      check_eq($sformatf("t4_data%0d", k), 32'(data_out), 32'(k));
    end
    data_rd = 1'b0;
    tick();
    check_eq("t4_idle", 32'(valid_out), 32'h0);
    check_eq("t4_empty", 32'(rcv_rdy), 32'h0);

    // 5. continuous push+pop across pointer wrap
    for (int k = 0; k < 20; k++) begin
      set_lane(0, 8'h00, 8'(8'h20 + k));
      valid_in = 4'b0001;
      data_rd  = (k > 0);
      #1;
      check_eq($sformatf("t5_grant%0d", k), 32'(grant), 32'h1);
      tick();
      if (k > 0) begin
        check_eq($sformatf("t5_valid%0d", k), 32'(valid_out), 32'h1);
        check_eq($sformatf("t5_data%0d", k), 32'(data_out), 32'(8'h20 + k - 1));
      end
      check_eq($sformatf("t5_count%0d", k), 32'(dut.count_q), 32'h1);
    end
    valid_in = '0;
    data_rd  = 1'b1;
    tick();
    data_rd = 1'b0;
    check_eq("t5_last_data", 32'(data_out), 32'h33);
    tick();
    check_eq("t5_empty", 32'(rcv_rdy), 32'h0);

    // 6. reset mid-stream; rr was 1 beforehand, so lane 0 winning proves the restart
    for (int k = 0; k < 3; k++) begin
      set_lane(0, 8'h00, 8'(8'h40 + k));
      valid_in = 4'b0001;
      tick();
    end
    for (int i = 0; i < 4; i++) set_lane(i, 8'h00, 8'(8'h50 + i));
    valid_in = 4'b1111;
    data_rd  = 1'b1;
    reset    = 1'b0;
    #1;
    check_eq("t6_grant_in_reset", 32'(grant), 32'h0);
    tick();
    check_eq("t6_valid_out", 32'(valid_out), 32'h0);
    check_eq("t6_rcv_rdy", 32'(rcv_rdy), 32'h0);
    reset   = 1'b1;
    data_rd = 1'b0;
    #1;
    check_eq("t6_rr_restart", 32'(grant), 32'h1);
    tick();
    valid_in = '0;
    check_eq("t6_rdy_after", 32'(rcv_rdy), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/switch_out_port.md
# switch_out_port

Output-port stage of the 4-port packet switch: one instance per output port sits between the four input ports (`addr_in`/`data_in`/`valid_in`) and that port's receiver-side signals (`addr_out`/`data_out`/`valid_out`/`rcv_rdy`/`data_rd`). It claims bytes whose destination address matches its port address and arbitrates round-robin among contending inputs. Accepted (addr, data) pairs go into a FIFO, which drains to the receiver under the `rcv_rdy`/`data_rd` handshake.

## Interface
Parameters:
- `PORT_ADDR`, 8'h00: destination address owned by this output port.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-low reset.
- `addr_in`  in  32  four 8-bit destination addresses; lane i = bits [8i+7:8i].
- `data_in`  in  32  four 8-bit data bytes, same lane packing.
- `valid_in`  in  4  lane i offers a byte.
- `grant`  out  4  one-hot; lane i's byte accepted this cycle.
- `addr_out`  out  8  address of delivered byte.
- `data_out`  out  8  delivered byte.
- `valid_out`  out  1  `addr_out`/`data_out` valid this cycle.
- `rcv_rdy`  out  1  FIFO non-empty.
- `data_rd`  in  1  receiver read request.

## Operation
- **Match:** lane i requests when `valid_in[i] && addr_in[8i+:8] == PORT_ADDR`. Non-matching lanes are ignored and never granted.
- **Arbitration:** round-robin, at most one grant per cycle.
  - A pointer `rr` (2 bits, reset 0) names the highest-priority lane. Search order is rr, rr+1, … mod 4.
  - After a grant to lane k, `rr` ← k+1 mod 4. With no grant, `rr` is unchanged.
- **Grant:** issued combinationally in the same cycle as the request when space is available. Space means `count < DEPTH`, or `count == DEPTH` with a pop this cycle.
  - Input lanes hold `valid_in`/`addr_in`/`data_in` until they see `grant[i]`.
  - On grant, {addr, data} of lane k is written at the next posedge.
- **Pop:** when `data_rd && rcv_rdy`, the head entry is read.
  - The next cycle drives `valid_out`=1 for exactly one cycle with that entry on `addr_out`/`data_out`.
  - `data_rd` while empty is ignored: no `valid_out`, no state change.
- **Simultaneous push and pop:** both take effect; `count` is unchanged. Push-when-full-with-pop is legal.
- **Pointers:** wr/rd pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits, range 0..DEPTH.
- **Reset values:**
  - `grant`=0, `valid_out`=0, `addr_out`=0, `data_out`=0, `rcv_rdy`=0.
  - `count`=0, pointers 0, `rr`=0.
- **Reset mid-operation:** FIFO contents are discarded and a pending `valid_out` is cancelled. `grant` is forced 0 while `reset`=0.
- **Arbiter FSM:** none; state is `rr` only.
- **Output FSM:** states IDLE and DELIVER.
  - IDLE → DELIVER on a legal pop.
  - DELIVER → DELIVER on another legal pop; otherwise → IDLE.
  - `valid_out` = (state == DELIVER).

## Timing
- `grant` is combinational from `valid_in`, `addr_in`, `rr`, `count` and `data_rd`. There is no combinational path from `data_rd` to `valid_out`.
- Push-to-`rcv_rdy`: a byte granted in cycle N raises `rcv_rdy` in cycle N+1.
- Read latency: `data_rd` in cycle N gives `valid_out` with data in cycle N+1.
- Back-to-back `data_rd` gives back-to-back `valid_out`, one byte per cycle.
- `rcv_rdy` is registered-derived (`count != 0`). It reflects pushes and pops of the previous edge.
- Throughput: 1 byte in and 1 byte out per cycle sustained.

## Structure
- Shared package `switch_pkg`:
  - `N_PORTS`=4 and `BYTE_W`=8.
  - `typedef struct packed { logic [7:0] addr; logic [7:0] data; } pkt_t` as the FIFO entry.
  - Lane-slice helper function.
- One sub-module is natural: `rr_arbiter4`. Inputs are the request vector, `rr` and an enable. Outputs are the one-hot grant and the next `rr`.
- The FIFO stays inline as a register array.

## Test plan
1. **Reset and pass-through.** After reset: all outputs 0. Then lane 2: `valid_in`=4'b0100, addr 8'h00, data 8'hA5.
   - Required: `grant`=4'b0100 the same cycle; `rcv_rdy`=1 next cycle.
   - Then `data_rd`=1: the following cycle gives `valid_out`=1, `addr_out`=00, `data_out`=A5; `rcv_rdy`=0 afterwards.
2. **Contention.** All four lanes hold matching requests with data 10/11/12/13.
   - Required: grants in order lane0, lane1, lane2, lane3, one per cycle.
   - Drain order is 10, 11, 12, 13.
3. **Address filter.** Lane 1 holds addr 8'h03 with `PORT_ADDR`=0.
   - Required: `grant[1]` is never asserted and the FIFO stays empty.
4. **Full.** Push 8 bytes 00..07 with no reads.
   - Required: the 9th request gets no grant while `rcv_rdy`=1.
   - When `data_rd` is asserted in the same cycle as the 9th request, the grant is given. The drain then yields 00..07, then the 9th byte.
5. **Wrap and simultaneous.** Run 20 cycles of continuous push+pop, bytes 0x20..0x33.
   - Required: output bytes equal the input bytes in order, `count` stays 1, no drops across pointer wrap.
6. **Reset mid-stream.** Push 3 bytes, assert `data_rd`, and drop `reset` in the same cycle.
   - Required: next cycle `valid_out`=0, `rcv_rdy`=0, and the arbiter restarts at lane 0.
